// File: rtl/word_mux_pkg.sv
// -----------------------------------------------------------------------------
// word_mux_pkg
// Shared helpers for the word_mux multiplexer and its combinational core.
//   num_in(sel_w)          : number of mux inputs, 2**sel_w
//   elem_slice(k, data_w)  : bit offset of element k inside the packed bus
// -----------------------------------------------------------------------------
package word_mux_pkg;

  // Usable in parameter and port-width expressions (constant function).
  function automatic int num_in(input int sel_w);
    return 2 ** sel_w;
  endfunction

  // Element k occupies in_bus[k*data_w +: data_w]; element 0 sits at the LSBs.
  function automatic int unsigned elem_slice(input int unsigned k,
                                             input int unsigned data_w);
    return k * data_w;
  endfunction

endpackage : word_mux_pkg

// File: rtl/word_mux_core.sv
// -----------------------------------------------------------------------------
// word_mux_core
// Purely combinational 2**SEL_W-to-1 word selector, built as a log2 tree of
// 2:1 stages. Stage j halves the candidate set using i_sel[j], so stage 0
// chooses between adjacent elements and the last stage uses the select MSB.
//
// Ports:
//   i_sel      [SEL_W-1:0]          index of the element to select
//   i_in_bus   [NUM_IN*DATA_W-1:0]  packed elements, element 0 at the LSBs
//   o_sel_data [DATA_W-1:0]         selected element
// -----------------------------------------------------------------------------
module word_mux_core
  import word_mux_pkg::*;
#(
  parameter int SEL_W  = 2,
  parameter int DATA_W = 1
) (
  input  logic [SEL_W-1:0]                i_sel,
  input  logic [num_in(SEL_W)*DATA_W-1:0] i_in_bus,
  output logic [DATA_W-1:0]               o_sel_data
);

  localparam int NUM_IN = num_in(SEL_W);
  // Offset width with one spare bit so k*DATA_W can never wrap.
  localparam int OFF_W  = SEL_W + $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] w_lvl [NUM_IN];
  logic [OFF_W-1:0]  w_off;

  always_comb begin
    // NOTE: every element of w_lvl (and w_off) is assigned before it is read
    // on every pass, so this block stays combinational and infers no latch.
    w_off = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_off    = OFF_W'(elem_slice(k, DATA_W));
      w_lvl[k] = i_in_bus[w_off +: DATA_W];
    end

    // In-place reduction: slot m of stage j takes slot 2m or 2m+1 of stage
    // j-1. Slots are rewritten in increasing order, so sources are never
    // clobbered before they are read.
    for (int j = 0; j < SEL_W; j++) begin
      for (int m = 0; m < (NUM_IN >> (j + 1)); m++) begin
        w_lvl[m] = i_sel[j] ? w_lvl[2*m + 1] : w_lvl[2*m];
      end
    end

    o_sel_data = w_lvl[0];
  end

endmodule : word_mux_core

// File: rtl/word_mux.sv
// -----------------------------------------------------------------------------
// word_mux
// Parameterized 2**SEL_W-to-1 multiplexer selecting one DATA_W-bit element
// from a flat packed bus. Default build registers the output (one cycle
// latency, asynchronous active-high reset, load enable).
//
// Build option:
//   WORD_MUX_COMB_OUT_EN  when defined, out follows the selected element
//                         combinationally; clk, rst and en are ignored but
//                         kept so instantiations are identical.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset (out -> 0)
//   en      load enable for the output register
//   sel     [SEL_W-1:0]          element index
//   in_bus  [NUM_IN*DATA_W-1:0]  packed elements, element 0 at the LSBs
//   out     [DATA_W-1:0]         selected element
// -----------------------------------------------------------------------------
module word_mux
  import word_mux_pkg::*;
#(
  parameter int SEL_W  = 2,
  parameter int DATA_W = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [SEL_W-1:0]                sel,
  input  logic [num_in(SEL_W)*DATA_W-1:0] in_bus,
  output logic [DATA_W-1:0]               out
);

  logic [DATA_W-1:0] w_sel_data;

  word_mux_core #(
    .SEL_W  (SEL_W),
    .DATA_W (DATA_W)
  ) u_core (
    .i_sel      (sel),
    .i_in_bus   (in_bus),
    .o_sel_data (w_sel_data)
  );

`ifdef WORD_MUX_COMB_OUT_EN

  // Clock, reset and enable have no function in this build.
  logic w_unused;
  assign w_unused = ^{clk, rst, en};

  assign out = w_sel_data;

`else

  logic [DATA_W-1:0] r_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (en) begin
      r_out <= w_sel_data;
    end
  end

  assign out = r_out;

`endif

endmodule : word_mux

// File: tb/tb_word_mux.sv
// -----------------------------------------------------------------------------
// tb_word_mux
// Scoreboard bench for word_mux. Two instances: SEL_W=2/DATA_W=1 and
// SEL_W=2/DATA_W=8. Stimulus pushes expected outputs into a queue; a monitor
// pops one entry per sampling point (rising clock edge + 1, or an explicit
// asynchronous sample request) and compares.
// -----------------------------------------------------------------------------
module tb_word_mux;

  typedef struct {
    bit         c1;
    logic       x1;
    bit         c8;
    logic [7:0] x8;
    string      nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en1, en8;
  logic [1:0]  sel1, sel8;
  logic [3:0]  in1;
  logic [31:0] in8;
  logic        out1;
  logic [7:0]  out8;

  exp_t q[$];
  event async_ev;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  word_mux #(.SEL_W(2), .DATA_W(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .en     (en1),
    .sel    (sel1),
    .in_bus (in1),
    .out    (out1)
  );

  word_mux #(.SEL_W(2), .DATA_W(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .en     (en8),
    .sel    (sel8),
    .in_bus (in8),
    .out    (out8)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Monitor: one queue entry per sampling point.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.c1) check({e.nm, " out1"}, 32'(out1), 32'(e.x1));
        if (e.c8) check({e.nm, " out8"}, 32'(out8), 32'(e.x8));
      end
    end
  end

  task automatic drive(input logic r, input logic e1, input logic [1:0] s1,
                       input logic [3:0] b1, input logic e8, input logic [1:0] s8,
                       input logic [31:0] b8);
    rst  = r;
    en1  = e1;
    sel1 = s1;
    in1  = b1;
    en8  = e8;
    sel8 = s8;
    in8  = b8;
  endtask

  function automatic exp_t mk(input bit c1, input logic x1, input bit c8,
                              input logic [7:0] x8, input string nm);
    exp_t e;
    e.c1 = c1;
    e.x1 = x1;
    e.c8 = c8;
    e.x8 = x8;
    e.nm = nm;
    return e;
  endfunction

  // Drive on the falling edge; expectation is checked after the next rising edge.
  task automatic step(input logic r, input logic e1, input logic [1:0] s1,
                      input logic [3:0] b1, input logic e8, input logic [1:0] s8,
                      input logic [31:0] b8, input bit c1, input logic x1,
                      input bit c8, input logic [7:0] x8, input string nm);
    @(negedge clk);
    drive(r, e1, s1, b1, e8, s8, b8);
    q.push_back(mk(c1, x1, c8, x8, nm));
  endtask

  // Request an immediate sample, independent of the clock.
  task automatic sample_now(input bit c1, input logic x1, input bit c8,
                            input logic [7:0] x8, input string nm);
    q.push_back(mk(c1, x1, c8, x8, nm));
    -> async_ev;
    #2;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] BUS8 = 32'hDDCCBBAA;

  initial begin : stim
    logic [3:0] bv;
    logic [7:0] tbl [4];
    tbl[0] = 8'hAA;
    tbl[1] = 8'hBB;
    tbl[2] = 8'hCC;
    tbl[3] = 8'hDD;

`ifdef WORD_MUX_COMB_OUT_EN
    // Combinational build: reset held and enables low to show they are ignored.
    drive(1'b1, 1'b0, 2'd1, 4'b1010, 1'b0, 2'd0, BUS8);
    #1;
    sample_now(1, 1'b1, 1, 8'hAA, "comb_1010_sel1");
    sel1 = 2'd2;
    sel8 = 2'd3;
    #1;
    sample_now(1, 1'b0, 1, 8'hDD, "comb_1010_sel2");
    for (int b = 0; b < 16; b++) begin
      for (int s = 0; s < 4; s++) begin
        bv   = 4'(b);
        in1  = bv;
        sel1 = 2'(s);
        sel8 = 2'(s);
        #1;
        sample_now(1, bv[s], 1, tbl[s], "comb_exhaustive");
      end
    end
`else
    // Reset takes effect with no clock edge.
    drive(1'b1, 1'b1, 2'd3, 4'b1111, 1'b0, 2'd0, BUS8);
    #2;
    sample_now(1, 1'b0, 1, 8'h00, "reset_immediate");
    step(1'b1, 1'b1, 2'd3, 4'b1111, 1'b0, 2'd0, BUS8, 1, 1'b0, 1, 8'h00, "reset_held");
    step(1'b0, 1'b1, 2'd3, 4'b1111, 1'b0, 2'd0, BUS8, 1, 1'b1, 1, 8'h00, "reset_release");

    // Exhaustive 1-bit select.
    for (int b = 0; b < 16; b++) begin
      for (int s = 0; s < 4; s++) begin
        bv = 4'(b);
        step(1'b0, 1'b1, 2'(s), bv, 1'b0, 2'd0, BUS8, 1, bv[s], 0, 8'h00, "exhaustive_1b");
      end
    end
    step(1'b0, 1'b1, 2'd1, 4'b0100, 1'b0, 2'd0, BUS8, 1, 1'b0, 0, 8'h00, "ex_0100_sel1");
    step(1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 2'd0, BUS8, 1, 1'b1, 0, 8'h00, "ex_0100_sel2");

    // 8-bit elements; out1 holds 1 with its enable low.
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, BUS8, 1, 1'b1, 1, 8'hAA, "w8_sel0");
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, BUS8, 0, 1'b0, 1, 8'hDD, "w8_sel3");
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, BUS8, 0, 1'b0, 1, 8'hBB, "w8_load_bb");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, BUS8, 1, 1'b1, 1, 8'hBB, "w8_en_hold");
    end
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, BUS8, 0, 1'b0, 1, 8'hCC, "w8_en_resume");
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 32'h12345678, 0, 1'b0, 1, 8'h56, "w8_sel_bus_change");
    step(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, BUS8, 0, 1'b0, 1, 8'hDD, "w8_pre_reset");

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2;
    rst = 1'b1;
    sample_now(1, 1'b0, 1, 8'h00, "midstream_reset");
    // First edge after release: dut8 loads (en=1), dut1 must not (en=0).
    step(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, 2'd0, BUS8, 1, 1'b0, 1, 8'hAA, "post_reset_load");
    step(1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 2'd0, BUS8, 1, 1'b1, 1, 8'hAA, "post_reset_en1");
`endif

    repeat (2) @(posedge clk);
    #3;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_word_mux
